fwd_hazard_unit: RTL and testbench

Parametrised forwarding and hazard unit for the RISC-V pipeline. It replaces the fixed two-operand MEM/WB forwarding logic. It tracks destination tags of in-flight instructions across `DEPTH` post-EX stages and produces per-source forward selects for `NUM_SRC` operands. It also generates load-use stalls and a variable-latency memory-wait freeze with a timeout error. It sits beside the ID/EX/MEM pipeline registers and drives the EX operand muxes and the pipeline enables.

---
 rtl/fwd_hazard_unit.sv | 156 +++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding/hazard unit: post-EX destination tag pipeline, per-source forward selects,
// load-use stall and memory-wait freeze with timeout. Optional stall counters: FWD_STALL_STATS_EN.
module fwd_hazard_unit #(
  parameter int NUM_SRC     = 2,
  parameter int DEPTH       = 2,
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 15,
  localparam int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ex_valid,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic                      ex_regwrite,
  input  logic                      ex_is_load,
  input  logic [NUM_SRC*REG_AW-1:0] ex_rs,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic                      mem_ready,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      stall_id,
  output logic                      stall_all,
  output logic                      mem_err
`ifdef FWD_STALL_STATS_EN
  ,
  output logic [31:0]               stall_id_cnt,
  output logic [31:0]               stall_all_cnt
`endif
);

  typedef enum logic {RUN, WAIT} state_t;

  logic              tag_valid_reg [DEPTH];
  logic [REG_AW-1:0] tag_rd_reg    [DEPTH];
  // Only the entry-1 load flag ever matters, so deeper stages do not carry it.
  logic              entry1_load_reg;
  logic              ld_done_reg;
  state_t            state_reg, state_next;
  logic [7:0]        wait_cnt_reg, wait_cnt_next;
  logic              mem_err_next;
  logic              ld_done_next;

  logic              ex_tag_valid;
  logic              entry1_pending;
  logic              timeout_hit;
  logic [NUM_SRC-1:0] use_hit;

  assign ex_tag_valid   = ex_valid & ex_regwrite & (ex_rd != '0);
  assign entry1_pending = tag_valid_reg[0] & entry1_load_reg & ~ld_done_reg;
  assign timeout_hit    = (state_reg == WAIT) & ~mem_ready & (wait_cnt_reg == 8'(MEM_TIMEOUT));

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REG_AW-1:0] ex_src;
      logic [REG_AW-1:0] id_src;
      logic [SEL_W-1:0]  sel_s;

      assign ex_src = ex_rs[gi*REG_AW +: REG_AW];
      assign id_src = id_rs[gi*REG_AW +: REG_AW];

      // Scan from the oldest stage down so the nearest match overwrites.
      always_comb begin
        sel_s = '0;
        for (int k = DEPTH; k >= 1; k--) begin
          if (tag_valid_reg[k-1] && (tag_rd_reg[k-1] == ex_src) && (ex_src != '0))
            sel_s = SEL_W'(k);
        end
      end

      assign fwd_sel[gi*SEL_W +: SEL_W] = sel_s;
      assign use_hit[gi] = id_rs_used[gi] & (id_src == ex_rd);
    end
  endgenerate

  assign stall_all = ((state_reg == WAIT) & ~mem_ready) |
                     ((state_reg == RUN) & entry1_pending & ~mem_ready);
  assign stall_id  = ex_tag_valid & ex_is_load & (|use_hit) & ~stall_all;

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    mem_err_next  = mem_err;
    ld_done_next  = ld_done_reg;
    case (state_reg)
      RUN: begin
        if (entry1_pending && !mem_ready) begin
          state_next    = WAIT;
          wait_cnt_next = 8'd1;
        end
      end
      WAIT: begin
        if (mem_ready) begin
          state_next    = RUN;
          wait_cnt_next = 8'd0;
        end else if (timeout_hit) begin
          state_next    = RUN;
          wait_cnt_next = 8'd0;
          mem_err_next  = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_reg + 8'd1;
        end
      end
      default: state_next = RUN;
    endcase
    // A timed-out load counts as complete until the tags move past it.
    if (timeout_hit)
      ld_done_next = 1'b1;
    else if (!stall_all)
      ld_done_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= RUN;
      wait_cnt_reg <= 8'd0;
      mem_err      <= 1'b0;
      ld_done_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      mem_err      <= mem_err_next;
      ld_done_reg  <= ld_done_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        tag_valid_reg[k] <= 1'b0;
        tag_rd_reg[k]    <= '0;
      end
      entry1_load_reg <= 1'b0;
    end else if (!stall_all) begin
      tag_valid_reg[0] <= ex_tag_valid;
      tag_rd_reg[0]    <= ex_rd;
      entry1_load_reg  <= ex_is_load;
      for (int k = 1; k < DEPTH; k++) begin
        tag_valid_reg[k] <= tag_valid_reg[k-1];
        tag_rd_reg[k]    <= tag_rd_reg[k-1];
      end
    end
  end

`ifdef FWD_STALL_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_id_cnt  <= 32'd0;
      stall_all_cnt <= 32'd0;
    end else begin
      if (stall_id)  stall_id_cnt  <= stall_id_cnt + 32'd1;
      if (stall_all) stall_all_cnt <= stall_all_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: a default instance (2 sources, depth 2) and a
// wide instance (3 sources, depth 4, timeout 3).
module tb_fwd_hazard_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Instance A: defaults.
  logic        a_ex_valid, a_ex_regwrite, a_ex_is_load, a_mem_ready;
  logic [4:0]  a_ex_rd;
  logic [9:0]  a_ex_rs, a_id_rs;
  logic [1:0]  a_id_rs_used;
  logic [3:0]  a_fwd_sel;
  logic        a_stall_id, a_stall_all, a_mem_err;

  // Instance B: NUM_SRC=3, DEPTH=4, MEM_TIMEOUT=3.
  logic        b_ex_valid, b_ex_regwrite, b_ex_is_load, b_mem_ready;
  logic [4:0]  b_ex_rd;
  logic [14:0] b_ex_rs, b_id_rs;
  logic [2:0]  b_id_rs_used;
  logic [8:0]  b_fwd_sel;
  logic        b_stall_id, b_stall_all, b_mem_err;

`ifdef FWD_STALL_STATS_EN
  logic [31:0] a_sid_cnt, a_sall_cnt, b_sid_cnt, b_sall_cnt;
`endif

  fwd_hazard_unit dut_a (
    .clk(clk), .reset(reset), .ex_valid(a_ex_valid), .ex_rd(a_ex_rd),
    .ex_regwrite(a_ex_regwrite), .ex_is_load(a_ex_is_load), .ex_rs(a_ex_rs),
    .id_rs(a_id_rs), .id_rs_used(a_id_rs_used), .mem_ready(a_mem_ready),
    .fwd_sel(a_fwd_sel), .stall_id(a_stall_id), .stall_all(a_stall_all),
    .mem_err(a_mem_err)
`ifdef FWD_STALL_STATS_EN
    , .stall_id_cnt(a_sid_cnt), .stall_all_cnt(a_sall_cnt)
`endif
  );

  fwd_hazard_unit #(.NUM_SRC(3), .DEPTH(4), .REG_AW(5), .MEM_TIMEOUT(3)) dut_b (
    .clk(clk), .reset(reset), .ex_valid(b_ex_valid), .ex_rd(b_ex_rd),
    .ex_regwrite(b_ex_regwrite), .ex_is_load(b_ex_is_load), .ex_rs(b_ex_rs),
    .id_rs(b_id_rs), .id_rs_used(b_id_rs_used), .mem_ready(b_mem_ready),
    .fwd_sel(b_fwd_sel), .stall_id(b_stall_id), .stall_all(b_stall_all),
    .mem_err(b_mem_err)
`ifdef FWD_STALL_STATS_EN
    , .stall_id_cnt(b_sid_cnt), .stall_all_cnt(b_sall_cnt)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a;
    a_ex_valid = 0; a_ex_rd = 0; a_ex_regwrite = 0; a_ex_is_load = 0;
    a_ex_rs = 0; a_id_rs = 0; a_id_rs_used = 0; a_mem_ready = 1;
  endtask

  task automatic idle_b;
    b_ex_valid = 0; b_ex_rd = 0; b_ex_regwrite = 0; b_ex_is_load = 0;
    b_ex_rs = 0; b_id_rs = 0; b_id_rs_used = 0; b_mem_ready = 1;
  endtask

  task automatic test_reset;
    reset = 1; idle_a(); idle_b();
    tick(); tick();
    reset = 0;
    a_ex_rs = {5'd5, 5'd5};
    @(negedge clk);
    total_cnt++;
    if ({a_fwd_sel, a_stall_id, a_stall_all, a_mem_err} !== 7'd0)
      $display("FAIL reset_a: fwd/sid/sall/err=%b want 0000000", {a_fwd_sel, a_stall_id, a_stall_all, a_mem_err});
    else pass_cnt++;
    total_cnt++;
    if ({b_fwd_sel, b_stall_id, b_stall_all, b_mem_err} !== 12'd0)
      $display("FAIL reset_b: fwd/sid/sall/err=%b want 0", {b_fwd_sel, b_stall_id, b_stall_all, b_mem_err});
    else pass_cnt++;
    tick(); idle_a();
  endtask

  task automatic test_basic_fwd;
    a_ex_valid = 1; a_ex_regwrite = 1; a_ex_rd = 5;
    tick();
    a_ex_regwrite = 0; a_ex_rd = 0; a_ex_rs = {5'd0, 5'd5};
    @(negedge clk);
    total_cnt++;
    if (a_fwd_sel !== 4'b0001) $display("FAIL basic_mem: fwd_sel=%b want 0001", a_fwd_sel);
    else pass_cnt++;
    tick();
    @(negedge clk);
    total_cnt++;
    if (a_fwd_sel !== 4'b0010) $display("FAIL basic_wb: fwd_sel=%b want 0010", a_fwd_sel);
    else pass_cnt++;
    tick(); idle_a(); tick();
  endtask

  task automatic test_nearest;
    a_ex_valid = 1; a_ex_regwrite = 1; a_ex_rd = 7;
    tick();
    tick();
    // Consumer that also writes x0 (which must not become a tag).
    a_ex_rd = 0; a_ex_rs = {5'd7, 5'd7};
    @(negedge clk);
    total_cnt++;
    if (a_fwd_sel !== 4'b0101) $display("FAIL nearest_wins: fwd_sel=%b want 0101", a_fwd_sel);
    else pass_cnt++;
    tick();
    @(negedge clk);
    total_cnt++;
    if (a_fwd_sel !== 4'b1010) $display("FAIL x0_entry1: fwd_sel=%b want 1010", a_fwd_sel);
    else pass_cnt++;
    tick();
    @(negedge clk);
    total_cnt++;
    if (a_fwd_sel !== 4'b0000) $display("FAIL x0_never: fwd_sel=%b want 0000", a_fwd_sel);
    else pass_cnt++;
    tick(); idle_a(); tick();
  endtask

  task automatic test_load_use;
    a_ex_valid = 1; a_ex_regwrite = 1; a_ex_is_load = 1; a_ex_rd = 3;
    a_id_rs = {5'd0, 5'd3}; a_id_rs_used = 2'b01;
    @(negedge clk);
    total_cnt++;
    if (a_stall_id !== 1'b1) $display("FAIL load_use_stall: stall_id=%b want 1", a_stall_id);
    else pass_cnt++;
    tick();
    a_ex_valid = 0; a_ex_regwrite = 0; a_ex_is_load = 0; a_ex_rd = 0;
    @(negedge clk);
    total_cnt++;
    if ({a_stall_id, a_stall_all} !== 2'b00) $display("FAIL load_use_once: sid/sall=%b want 00", {a_stall_id, a_stall_all});
    else pass_cnt++;
    tick();
    a_ex_valid = 1; a_ex_rs = {5'd0, 5'd3}; a_id_rs = 0; a_id_rs_used = 0;
    @(negedge clk);
    total_cnt++;
    if (a_fwd_sel !== 4'b0010) $display("FAIL load_use_fwd: fwd_sel=%b want 0010", a_fwd_sel);
    else pass_cnt++;
    tick();
    a_ex_regwrite = 1; a_ex_is_load = 1; a_ex_rd = 3; a_ex_rs = 0;
    a_id_rs = {5'd0, 5'd3}; a_id_rs_used = 2'b10;
    @(negedge clk);
    total_cnt++;
    if (a_stall_id !== 1'b0) $display("FAIL load_use_unused: stall_id=%b want 0", a_stall_id);
    else pass_cnt++;
    tick(); idle_a(); tick();
  endtask

  task automatic test_mem_wait;
    a_ex_valid = 1; a_ex_regwrite = 1; a_ex_is_load = 1; a_ex_rd = 4;
    tick();
    // Load x4 now in stage 1; EX holds a load to x6 that ID depends on.
    a_mem_ready = 0; a_ex_rd = 6; a_ex_rs = {5'd0, 5'd4};
    a_id_rs = {5'd0, 5'd6}; a_id_rs_used = 2'b01;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total_cnt++;
      if ({a_stall_all, a_stall_id, a_mem_err, a_fwd_sel} !== 7'b1000001)
        $display("FAIL mem_wait_c%0d: sall/sid/err/fwd=%b want 1000001", i, {a_stall_all, a_stall_id, a_mem_err, a_fwd_sel});
      else pass_cnt++;
      tick();
    end
    a_mem_ready = 1;
    @(negedge clk);
    total_cnt++;
    if ({a_stall_all, a_stall_id} !== 2'b01) $display("FAIL mem_wait_release: sall/sid=%b want 01", {a_stall_all, a_stall_id});
    else pass_cnt++;
    tick();
    a_ex_valid = 0; a_ex_regwrite = 0; a_ex_is_load = 0; a_ex_rd = 0;
    a_id_rs_used = 0; a_ex_rs = {5'd6, 5'd4};
    @(negedge clk);
    total_cnt++;
    if ({a_stall_all, a_fwd_sel} !== 5'b00110) $display("FAIL mem_wait_resume: sall/fwd=%b want 00110", {a_stall_all, a_fwd_sel});
    else pass_cnt++;
`ifdef FWD_STALL_STATS_EN
    total_cnt++;
    if (a_sid_cnt !== 32'd2 || a_sall_cnt !== 32'd4)
      $display("FAIL stats_a: sid_cnt=%0d sall_cnt=%0d want 2 4", a_sid_cnt, a_sall_cnt);
    else pass_cnt++;
`endif
    tick(); idle_a(); tick();
  endtask

  task automatic test_wide_fwd;
    b_ex_valid = 1; b_ex_regwrite = 1; b_ex_rd = 9;
    tick();
    b_ex_valid = 0; b_ex_regwrite = 0; b_ex_rd = 0; b_ex_rs = {5'd9, 5'd0, 5'd0};
    @(negedge clk);
    total_cnt++;
    if (b_fwd_sel !== 9'b001_000_000) $display("FAIL wide_stage1: fwd_sel=%b want 001000000", b_fwd_sel);
    else pass_cnt++;
    tick(); tick(); tick();
    b_ex_valid = 1;
    @(negedge clk);
    total_cnt++;
    if (b_fwd_sel !== 9'b100_000_000) $display("FAIL wide_stage4: fwd_sel=%b want 100000000", b_fwd_sel);
    else pass_cnt++;
    tick(); idle_b(); tick();
  endtask

  task automatic test_timeout;
    b_ex_valid = 1; b_ex_regwrite = 1; b_ex_is_load = 1; b_ex_rd = 2;
    tick();
    idle_b(); b_mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total_cnt++;
      if ({b_stall_all, b_mem_err} !== 2'b10) $display("FAIL timeout_wait_c%0d: sall/err=%b want 10", i, {b_stall_all, b_mem_err});
      else pass_cnt++;
      tick();
    end
    @(negedge clk);
    total_cnt++;
    if ({b_stall_all, b_mem_err} !== 2'b01) $display("FAIL timeout_err: sall/err=%b want 01", {b_stall_all, b_mem_err});
    else pass_cnt++;
    tick();
    @(negedge clk);
    total_cnt++;
    if ({b_stall_all, b_mem_err} !== 2'b01) $display("FAIL timeout_sticky: sall/err=%b want 01", {b_stall_all, b_mem_err});
    else pass_cnt++;
`ifdef FWD_STALL_STATS_EN
    total_cnt++;
    if (b_sid_cnt !== 32'd0 || b_sall_cnt !== 32'd4)
      $display("FAIL stats_b: sid_cnt=%0d sall_cnt=%0d want 0 4", b_sid_cnt, b_sall_cnt);
    else pass_cnt++;
`endif
    tick();
    reset = 1;
    tick();
    reset = 0; b_mem_ready = 1;
    @(negedge clk);
    total_cnt++;
    if ({b_fwd_sel, b_stall_id, b_stall_all, b_mem_err} !== 12'd0)
      $display("FAIL timeout_reset: fwd/sid/sall/err=%b want 0", {b_fwd_sel, b_stall_id, b_stall_all, b_mem_err});
    else pass_cnt++;
`ifdef FWD_STALL_STATS_EN
    total_cnt++;
    if (b_sall_cnt !== 32'd0) $display("FAIL stats_reset: sall_cnt=%0d want 0", b_sall_cnt);
    else pass_cnt++;
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_fwd();
    test_nearest();
    test_load_use();
    test_mem_wait();
    test_wide_fwd();
    test_timeout();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
